// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control and tag pass-through.
// The log2(WIDTH) shift levels are spread over PIPE_DEPTH register stages; the last stage drives the outputs.
module pipelined_shifter #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = 5,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   Din,
  input  logic [SHAMT_W-1:0] Num,
  input  logic [1:0]         Op,
  input  logic [TAG_W-1:0]   InTag,
  input  logic               Flush,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   Dout,
  output logic [TAG_W-1:0]   OutTag,
  output logic               Zero
);

  localparam int LAST = PIPE_DEPTH - 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic int level_stage(input int lvl);
    return (lvl * PIPE_DEPTH) / SHAMT_W;
  endfunction

  // One barrel level; amt is always a power of two no larger than WIDTH/2.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input int               amt,
                                                   input logic [1:0]       op,
                                                   input logic             sgn);
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> amt) : {WIDTH{1'b0}};
    case (op)
      OP_SLL:  shift_level = d << amt;
      OP_SRL:  shift_level = d >> amt;
      OP_SRA:  shift_level = (d >> amt) | fill;
      OP_ROR:  shift_level = (d >> amt) | (d << (WIDTH - amt));
      default: shift_level = d;
    endcase
  endfunction

  logic [PIPE_DEPTH-1:0] valid_q;
  logic [PIPE_DEPTH-1:0] sign_q;
  logic [WIDTH-1:0]      data_q [PIPE_DEPTH];
  logic [SHAMT_W-1:0]    num_q  [PIPE_DEPTH];
  logic [1:0]            op_q   [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_q  [PIPE_DEPTH];
  logic                  zero_q;

  logic [PIPE_DEPTH-1:0] adv_s;
  logic [PIPE_DEPTH-1:0] in_valid_s;
  logic [PIPE_DEPTH-1:0] in_sign_s;
  logic [WIDTH-1:0]      in_data_s   [PIPE_DEPTH];
  logic [SHAMT_W-1:0]    in_num_s    [PIPE_DEPTH];
  logic [1:0]            in_op_s     [PIPE_DEPTH];
  logic [TAG_W-1:0]      in_tag_s    [PIPE_DEPTH];
  logic [WIDTH-1:0]      stage_out_s [PIPE_DEPTH];

  // A stage advances when it or any later stage is empty, or the consumer takes the result.
  always_comb begin
    adv_s = {PIPE_DEPTH{1'b0}};
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      logic any_empty;
      any_empty = 1'b0;
      for (int j = k; j < PIPE_DEPTH; j++) begin
        any_empty = any_empty | ~valid_q[j];
      end
      adv_s[k] = any_empty | OutReady;
    end
  end

  assign InReady = adv_s[0] & ~Flush;

  // Stage operands: stage 0 from the ports, later stages from the preceding register.
  always_comb begin
    in_valid_s   = {PIPE_DEPTH{1'b0}};
    in_sign_s    = {PIPE_DEPTH{1'b0}};
    in_valid_s[0] = InValid & InReady;
    in_sign_s[0]  = Din[WIDTH-1];
    in_data_s[0]  = Din;
    in_num_s[0]   = Num;
    in_op_s[0]    = Op;
    in_tag_s[0]   = InTag;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      in_valid_s[k] = valid_q[k-1];
      in_sign_s[k]  = sign_q[k-1];
      in_data_s[k]  = data_q[k-1];
      in_num_s[k]   = num_q[k-1];
      in_op_s[k]    = op_q[k-1];
      in_tag_s[k]   = tag_q[k-1];
    end
  end

  // Apply the shift levels owned by each stage.
  always_comb begin
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      stage_out_s[k] = in_data_s[k];
      for (int l = 0; l < SHAMT_W; l++) begin
        if ((level_stage(l) == k) && in_num_s[k][l]) begin
          stage_out_s[k] = shift_level(stage_out_s[k], 1 << l, in_op_s[k], in_sign_s[k]);
        end else begin
          stage_out_s[k] = stage_out_s[k];
        end
      end
    end
  end

  // Pipeline registers; data only loads with a valid operation so stalled outputs hold.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= {PIPE_DEPTH{1'b0}};
      sign_q  <= {PIPE_DEPTH{1'b0}};
      zero_q  <= 1'b0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        data_q[k] <= {WIDTH{1'b0}};
        num_q[k]  <= {SHAMT_W{1'b0}};
        op_q[k]   <= 2'b00;
        tag_q[k]  <= {TAG_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (Flush) begin
          valid_q[k] <= 1'b0;
        end else if (adv_s[k]) begin
          valid_q[k] <= in_valid_s[k];
        end
        if (adv_s[k] && in_valid_s[k]) begin
          data_q[k] <= stage_out_s[k];
          num_q[k]  <= in_num_s[k];
          op_q[k]   <= in_op_s[k];
          tag_q[k]  <= in_tag_s[k];
          sign_q[k] <= in_sign_s[k];
        end
      end
      if (adv_s[LAST] && in_valid_s[LAST]) begin
        zero_q <= (stage_out_s[LAST] == {WIDTH{1'b0}});
      end
    end
  end

  assign OutValid = valid_q[LAST];
  assign Dout     = data_q[LAST];
  assign OutTag   = tag_q[LAST];
  assign Zero     = zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32, PIPE_DEPTH=2, TAG_W=4).
module tb_pipelined_shifter;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
    logic        z;
  } exp_t;

  logic        Clk, Rst_n, InValid, InReady, Flush, OutValid, OutReady, Zero;
  logic [31:0] Din, Dout;
  logic [4:0]  Num;
  logic [1:0]  Op;
  logic [3:0]  InTag, OutTag;

  int   n_vec = 0, n_miss = 0;
  int   cyc = 0, last_pop = 0, prev_pop = 0;
  bit   rand_bp = 1'b0;
  exp_t sb[$];
  logic        stall_prev = 1'b0;
  logic [31:0] prev_dout;
  logic [3:0]  prev_tag;

  pipelined_shifter #(.WIDTH(32), .SHAMT_W(5), .PIPE_DEPTH(2), .TAG_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady), .Din(Din),
    .Num(Num), .Op(Op), .InTag(InTag), .Flush(Flush), .OutValid(OutValid),
    .OutReady(OutReady), .Dout(Dout), .OutTag(OutTag), .Zero(Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] d,
                                 input logic [4:0] n, input logic [3:0] t);
    logic [31:0] r;
    logic [63:0] dd;
    case (op)
      2'b00:   r = d << n;
      2'b01:   r = d >> n;
      2'b10:   r = $signed(d) >>> n;
      default: begin dd = {d, d} >> n; r = dd[31:0]; end
    endcase
    return '{d: r, t: t, z: (r == 32'd0)};
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake, hold check while stalled
  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (!Rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && OutValid) begin
        check("stall_dout", 64'(Dout), 64'(prev_dout));
        check("stall_tag", 64'(OutTag), 64'(prev_tag));
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(OutValid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("dout", 64'(Dout), 64'(e.d));
          check("tag", 64'(OutTag), 64'(e.t));
          check("zero", 64'(Zero), 64'(e.z));
          prev_pop = last_pop;
          last_pop = cyc;
        end
      end
      if (Flush) sb.delete();
      if (InValid && InReady) sb.push_back(model(Op, Din, Num, InTag));
      stall_prev = OutValid && !OutReady && !Flush;
      prev_dout  = Dout;
      prev_tag   = OutTag;
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] n,
                      input logic [3:0] t);
    bit acc = 1'b0;
    InValid = 1'b1; Op = op; Din = d; Num = n; InTag = t;
    for (int tries = 0; tries < 50 && !acc; tries++) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk); #1;
      if (rand_bp) OutReady = (tries > 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    InValid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  // Issue with no back-pressure and check the result appears exactly two cycles later
  task automatic timed_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] n,
                          input logic [3:0] t, input logic [31:0] exp_d, input logic exp_z);
    send(op, d, n, t);
    check("lat_early", 64'(OutValid), 64'd0);
    @(posedge Clk); #1;
    check("lat_valid", 64'(OutValid), 64'd1);
    check("lat_dout", 64'(Dout), 64'(exp_d));
    check("lat_tag", 64'(OutTag), 64'(t));
    check("lat_zero", 64'(Zero), 64'(exp_z));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge Clk);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc;
    Rst_n = 1'b0; InValid = 1'b0; Din = 32'd0; Num = 5'd0; Op = 2'b00; InTag = 4'd0;
    Flush = 1'b0; OutReady = 1'b1;
    #2;
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_dout", 64'(Dout), 64'd0);
    check("rst_tag", 64'(OutTag), 64'd0);
    check("rst_zero", 64'(Zero), 64'd0);
    check("rst_inready", 64'(InReady), 64'd1);
    @(posedge Clk); #1; Rst_n = 1'b1;
    @(posedge Clk); #1;

    timed_op(2'b00, 32'h0000_0001, 5'd31, 4'd3, 32'h8000_0000, 1'b0);
    drain();

    send(2'b10, 32'h8000_0000, 5'd4, 4'd1);
    send(2'b01, 32'h8000_0000, 5'd4, 4'd2);
    send(2'b00, 32'h0000_0001, 5'd0, 4'd4);
    send(2'b01, 32'h0000_0001, 5'd1, 4'd5);
    send(2'b11, 32'h1234_5678, 5'd8, 4'd6);
    send(2'b11, 32'h1234_5678, 5'd0, 4'd7);
    drain();
    check("b2b_spacing", 64'(last_pop - prev_pop), 64'd1);

    // Back-pressure: only two operations fit
    OutReady = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      InValid = 1'b1; Op = 2'b11; Num = 5'(i + 3); InTag = 4'(acc); Din = 32'hA5C3_0F00 | 32'(acc);
      @(negedge Clk);
      if (InReady) acc++;
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_inready", 64'(InReady), 64'd0);
    OutReady = 1'b1;
    send(2'b11, 32'hA5C3_0F02, 5'd9, 4'd2);
    send(2'b11, 32'hA5C3_0F03, 5'd10, 4'd3);
    drain();

    // Flush with two in flight
    send(2'b00, 32'h0000_00FF, 5'd4, 4'd8);
    send(2'b01, 32'hFFFF_0000, 5'd8, 4'd9);
    Flush = 1'b1; InValid = 1'b1; InTag = 4'd10;
    @(negedge Clk);
    check("flush_inready", 64'(InReady), 64'd0);
    @(posedge Clk); #1;
    Flush = 1'b0; InValid = 1'b0;
    check("flush_outvalid", 64'(OutValid), 64'd0);
    @(posedge Clk); #1;
    check("flush_outvalid2", 64'(OutValid), 64'd0);
    timed_op(2'b10, 32'h8000_0001, 5'd1, 4'd11, 32'hC000_0000, 1'b0);
    drain();

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    end
    rand_bp = 1'b0; OutReady = 1'b1;
    drain();

    // Asynchronous reset with a full pipe
    OutReady = 1'b0;
    send(2'b00, 32'h0000_00F0, 5'd4, 4'd5);
    send(2'b01, 32'h0000_0001, 5'd1, 4'd6);
    #3 Rst_n = 1'b0;
    #1;
    check("amid_outvalid", 64'(OutValid), 64'd0);
    check("amid_dout", 64'(Dout), 64'd0);
    check("amid_zero", 64'(Zero), 64'd0);
    check("amid_inready", 64'(InReady), 64'd1);
    @(posedge Clk); #1; Rst_n = 1'b1; OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      check("post_rst_outvalid", 64'(OutValid), 64'd0);
    end
    timed_op(2'b01, 32'h8000_0000, 5'd4, 4'd12, 32'h0800_0000, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
